// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates three result producers (alu, lsb, br) onto one
// registered common data bus with a single output slot.
// Arbitration policy is chosen by the macro CDB_ROUND_ROBIN_EN:
//   defined   -> round-robin starting from rr_ptr
//   undefined -> fixed priority br > lsb > alu (no rr_ptr)
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | no broadcast held, cdb_valid_out = 0
// ST_FULL  | broadcast held on cdb outputs, cdb_valid_out = 1

module cdb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_in,
  input  logic              stall_in,
  input  logic              alu_valid_in,
  input  logic              lsb_valid_in,
  input  logic              br_valid_in,
  input  logic [TAG_W-1:0]  alu_tag_in,
  input  logic [TAG_W-1:0]  lsb_tag_in,
  input  logic [TAG_W-1:0]  br_tag_in,
  input  logic [WORD_W-1:0] alu_data_in,
  input  logic [WORD_W-1:0] lsb_data_in,
  input  logic [WORD_W-1:0] br_data_in,
  output logic              alu_ready_out,
  output logic              lsb_ready_out,
  output logic              br_ready_out,
  output logic              cdb_valid_out,
  output logic [TAG_W-1:0]  cdb_tag_out,
  output logic [WORD_W-1:0] cdb_data_out,
  output logic [1:0]        cdb_src_out
);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSB = 2'd1;
  localparam logic [1:0] SRC_BR  = 2'd2;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;

  logic              can_accept;
  logic              gnt_en;
  logic              gnt_any;
  logic [1:0]        gnt_idx;

`ifdef CDB_ROUND_ROBIN_EN
  logic [1:0]        rr_q, rr_d;
`endif

  // The slot takes a new result when empty or when the held one leaves this cycle.
  assign can_accept = (state_q == ST_EMPTY) || !stall_in;
  assign gnt_en     = can_accept && !rst && !clear_in;

  // Choose the winning requester among those with a valid result.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = SRC_ALU;
    if (gnt_en) begin
`ifdef CDB_ROUND_ROBIN_EN
      case (rr_q)
        SRC_LSB: begin
          if (lsb_valid_in)      begin gnt_any = 1'b1; gnt_idx = SRC_LSB; end
          else if (br_valid_in)  begin gnt_any = 1'b1; gnt_idx = SRC_BR;  end
          else if (alu_valid_in) begin gnt_any = 1'b1; gnt_idx = SRC_ALU; end
        end
        SRC_BR: begin
          if (br_valid_in)       begin gnt_any = 1'b1; gnt_idx = SRC_BR;  end
          else if (alu_valid_in) begin gnt_any = 1'b1; gnt_idx = SRC_ALU; end
          else if (lsb_valid_in) begin gnt_any = 1'b1; gnt_idx = SRC_LSB; end
        end
        default: begin
          if (alu_valid_in)      begin gnt_any = 1'b1; gnt_idx = SRC_ALU; end
          else if (lsb_valid_in) begin gnt_any = 1'b1; gnt_idx = SRC_LSB; end
          else if (br_valid_in)  begin gnt_any = 1'b1; gnt_idx = SRC_BR;  end
        end
      endcase
`else
      if (br_valid_in)       begin gnt_any = 1'b1; gnt_idx = SRC_BR;  end
      else if (lsb_valid_in) begin gnt_any = 1'b1; gnt_idx = SRC_LSB; end
      else if (alu_valid_in) begin gnt_any = 1'b1; gnt_idx = SRC_ALU; end
`endif
    end
  end

  assign alu_ready_out = gnt_any && (gnt_idx == SRC_ALU);
  assign lsb_ready_out = gnt_any && (gnt_idx == SRC_LSB);
  assign br_ready_out  = gnt_any && (gnt_idx == SRC_BR);

  // Slot next state: clear wins, then a transfer, then draining when not stalled.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    src_d   = src_q;
    if (clear_in) begin
      state_d = ST_EMPTY;
    end else if (gnt_any) begin
      state_d = ST_FULL;
      src_d   = gnt_idx;
      case (gnt_idx)
        SRC_LSB: begin tag_d = lsb_tag_in; data_d = lsb_data_in; end
        SRC_BR:  begin tag_d = br_tag_in;  data_d = br_data_in;  end
        default: begin tag_d = alu_tag_in; data_d = alu_data_in; end
      endcase
    end else if ((state_q == ST_FULL) && !stall_in) begin
      state_d = ST_EMPTY;
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  // Pointer advances past the winner only when a transfer actually happens.
  always_comb begin
    rr_d = rr_q;
    if (gnt_any) begin
      rr_d = (gnt_idx == SRC_BR) ? SRC_ALU : (gnt_idx + 2'd1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= SRC_ALU;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Output slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      tag_q   <= '0;
      data_q  <= '0;
      src_q   <= SRC_ALU;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign cdb_valid_out = (state_q == ST_FULL);
  assign cdb_tag_out   = tag_q;
  assign cdb_data_out  = data_q;
  assign cdb_src_out   = src_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter TAG_W, default 4, width of the ROB tag carried on the bus.
REQ-002 Parameter WORD_W, default 32, width of the result data.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 clear_in  input  1  flush on branch mispredict; discards the pending broadcast.
REQ-006 stall_in  input  1  ROB cannot accept a broadcast this cycle.
REQ-007 alu_valid_in / lsb_valid_in / br_valid_in  input  1 each  requester i has a result.
REQ-008 alu_tag_in / lsb_tag_in / br_tag_in  input  TAG_W each  ROB tag of that result.
REQ-009 alu_data_in / lsb_data_in / br_data_in  input  WORD_W each  result value.
REQ-010 alu_ready_out / lsb_ready_out / br_ready_out  output  1 each  grant, combinational; transfer when valid && ready.
REQ-011 cdb_valid_out  output  1  broadcast valid, registered.
REQ-012 cdb_tag_out  output  TAG_W  broadcast tag, registered.
REQ-013 cdb_data_out  output  WORD_W  broadcast data, registered.
REQ-014 cdb_src_out  output  2  source of the broadcast: 0 = alu, 1 = lsb, 2 = br.

Function
REQ-015 One output register, states EMPTY (cdb_valid_out=0) and FULL (cdb_valid_out=1), holds one granted result.
REQ-016 The register accepts a new result when EMPTY, or when FULL and stall_in=0.
REQ-017 When the register cannot accept, all ready outputs are 0.
REQ-018 At most one ready output is 1 in any cycle.
REQ-019 A ready is asserted only to a requester whose valid is 1.
REQ-020 A granted result appears on the cdb outputs in the next cycle, giving 1-cycle latency.
REQ-021 FULL with stall_in=1 holds tag, data and src unchanged.
REQ-022 FULL with stall_in=0 and no transfer goes to EMPTY next cycle.
REQ-023 FULL with stall_in=0 and a transfer loads the new result and stays FULL, giving back-to-back broadcasts.
REQ-024 clear_in=1 forces all ready outputs to 0 in the same cycle.
REQ-025 clear_in=1 sets cdb_valid_out=0 in the next cycle, overriding stall_in and any transfer.
REQ-026 clear_in has no effect on the round-robin pointer.
REQ-027 Round-robin pointer rr_ptr (2 bits, values 0..2) names the highest-priority requester.
REQ-028 rr_ptr moves to (granted index + 1) mod 3 only on a transfer, wrapping from 2 to 0.
REQ-029 Priority order is rr_ptr, rr_ptr+1, rr_ptr+2, all taken mod 3.
REQ-030 An ignored or stalled request keeps its position until it is granted.
REQ-031 The block never reads or alters the data or tag of any requester other than the one granted.

Reset
REQ-032 On rst=1 at a clock edge: cdb_valid_out=0, cdb_tag_out=0, cdb_data_out=0, cdb_src_out=0, rr_ptr=0.
REQ-033 While rst=1, all ready outputs are 0, whatever the other inputs are.
REQ-034 rst takes priority over clear_in and stall_in.
REQ-035 rst asserted while FULL and stalled drops the held broadcast with no transfer.

Configuration
REQ-036 The macro CDB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-037 With CDB_ROUND_ROBIN_EN defined, the block uses round-robin per REQ-027 to REQ-030.
REQ-038 Without CDB_ROUND_ROBIN_EN, the block uses fixed priority br > lsb > alu, and rr_ptr is absent.
REQ-039 Without CDB_ROUND_ROBIN_EN, all other requirements remain unchanged.

Verification
REQ-040 Reset: rst=1, then all three valid=1 -> cdb_valid_out=0, readys=0; after rst drops, alu is granted first (rr_ptr=0).
REQ-041 Fairness: all valid held for 6 cycles, stall=0 -> src sequence 0,1,2,0,1,2 with cdb_valid_out=1 each cycle.
REQ-042 Stall: lsb tag=5, data=0xDEADBEEF granted, then stall_in=1 for 3 cycles -> output held at tag 5 and 0xDEADBEEF, all readys 0; in the cycle stall drops, the next grant occurs.
REQ-043 Flush: FULL with tag=3, stall_in=1, clear_in=1, alu valid -> next cycle cdb_valid_out=0, alu_ready_out was 0 in the clear cycle.
REQ-044 Sparse requests: only br valid, tag=7, data=1 for one cycle -> br_ready_out=1; next cycle cdb_tag_out=7, src=2; the cycle after, cdb_valid_out=0.
REQ-045 Fixed-priority build: macro undefined, all valid -> br granted every cycle; alu is granted only once br and lsb are both idle.
